// File: rtl/race_pkg.sv
// race_pkg: shared phase encoding, LFSR constants and place-counter sizing
// for the red-light/green-light race controller and its place arbiter.
package race_pkg;

  // Phase encoding as seen on the `phase` output.
  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_GREEN     = 3'd2,
    PH_RED       = 3'd3,
    PH_DONE      = 3'd4
  } phase_e;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Place counter: 1-based, saturates at its all-ones value.
  localparam int unsigned        PLACE_W   = 3;
  localparam logic [PLACE_W-1:0] PLACE_MAX = '1;

  // Width of the per-phase tick counter and phase-length values.
  localparam int unsigned PHASE_LEN_W = 16;

  // Clamp a phase length so a light phase always lasts at least one tick.
  function automatic logic [PHASE_LEN_W-1:0] at_least_one(input logic [PHASE_LEN_W-1:0] v);
    return (v == '0) ? PHASE_LEN_W'(1) : v;
  endfunction

endpackage

// File: rtl/race_place_arbiter.sv
// race_place_arbiter: tracks which lanes have resolved (finished or out),
// queues finishers in a pending mask and grants one place per cycle to the
// lowest-index pending lane, with a saturating 1-based place counter.
module race_place_arbiter
  import race_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic [N_PLAYERS-1:0] finished,
  input  logic [N_PLAYERS-1:0] out,
  output logic [N_PLAYERS-1:0] win,
  output logic                 place_valid,
  output logic [PLACE_W-1:0]   place_num,
  output logic                 settled
);

  logic [N_PLAYERS-1:0] pending_q, pending_d;
  logic [N_PLAYERS-1:0] resolved_q, resolved_d;
  logic [N_PLAYERS-1:0] hit, req, grant;
  logic [PLACE_W-1:0]   place_q, place_d;
  logic                 found;

  // Resolve new lane events, pick the lowest pending lane, advance the counter.
  always_comb begin
    hit   = sample_en ? ((finished | out) & ~resolved_q) : '0;
    // A lane that is out in the same cycle it finishes is eliminated, not queued.
    req   = pending_q | (hit & finished & ~out);
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (req[i] && !found) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    pending_d  = req & ~grant;
    resolved_d = resolved_q | hit;
    place_d    = place_q;
    if (found) begin
      place_d = (place_q == PLACE_MAX) ? PLACE_MAX : place_q + 1'b1;
    end
    if (clear) begin
      pending_d  = '0;
      resolved_d = '0;
      grant      = '0;
      place_d    = PLACE_W'(1);
    end
    settled = (&resolved_d) && (pending_d == '0);
  end

  // Register masks, counter and the one-cycle grant outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q   <= '0;
      resolved_q  <= '0;
      place_q     <= '0;
      win         <= '0;
      place_valid <= 1'b0;
      place_num   <= '0;
    end else begin
      pending_q   <= pending_d;
      resolved_q  <= resolved_d;
      place_q     <= place_d;
      win         <= grant;
      place_valid <= |grant;
      place_num   <= (|grant) ? place_q : '0;
    end
  end

endmodule

// File: rtl/race_controller.sv
// race_controller: red-light/green-light race sequencer. Runs the tick
// prescaler, countdown and alternating light phases, drives enable/red, and
// hands finish-order arbitration to race_place_arbiter.
// Optional feature: define RACE_RANDOM_LIGHT_EN for LFSR-randomised phase
// lengths; otherwise GREEN_TICKS/RED_TICKS are used as fixed lengths.
module race_controller
  import race_pkg::*;
#(
  parameter int unsigned N_PLAYERS       = 4,
  parameter int unsigned TICK_DIV        = 1000,
  parameter int unsigned COUNTDOWN_TICKS = 3,
  parameter int unsigned GREEN_TICKS     = 8,
  parameter int unsigned RED_TICKS       = 4,
  parameter int unsigned RACE_TICKS      = 255
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] finished,
  input  logic [N_PLAYERS-1:0] out,
  output logic                 enable,
  output logic                 red,
  output logic [2:0]           phase,
  output logic [2:0]           countdown,
  output logic [N_PLAYERS-1:0] win,
  output logic                 place_valid,
  output logic [2:0]           place_num,
  output logic                 race_done
);

  localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  phase_e                 ph_q, ph_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [PHASE_LEN_W-1:0] pt_q, pt_d, cur_len;
  logic [7:0]             race_q, race_d;
  logic [2:0]             cd_q, cd_d;
  logic                   tick, clear, settled;

  assign tick      = (div_q == DIV_LAST);
  assign clear     = ((ph_q == PH_IDLE) || (ph_q == PH_DONE)) && start;
  assign phase     = ph_q;
  assign countdown = cd_q;

`ifdef RACE_RANDOM_LIGHT_EN
  logic [7:0]             lfsr_q;
  logic [PHASE_LEN_W-1:0] len_q, len_d;

  // Free-running LFSR, stepped every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Capture the randomised length of a light phase on entry to it.
  always_comb begin
    len_d = len_q;
    if (ph_d == PH_GREEN && ph_q != PH_GREEN) begin
      len_d = at_least_one(PHASE_LEN_W'(GREEN_TICKS / 2) + PHASE_LEN_W'(lfsr_q[2:0]));
    end else if (ph_d == PH_RED && ph_q != PH_RED) begin
      len_d = at_least_one(PHASE_LEN_W'(RED_TICKS / 2) + PHASE_LEN_W'(lfsr_q[1:0]));
    end
  end

  // Hold the current phase length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) len_q <= '0;
    else      len_q <= len_d;
  end

  assign cur_len = len_q;
`else
  assign cur_len = (ph_q == PH_RED) ? PHASE_LEN_W'(RED_TICKS) : PHASE_LEN_W'(GREEN_TICKS);
`endif

  // Next phase, countdown, race/phase tick counters and prescaler.
  always_comb begin
    ph_d   = ph_q;
    cd_d   = cd_q;
    race_d = race_q;
    pt_d   = pt_q;
    case (ph_q)
      PH_IDLE, PH_DONE: begin
        if (clear) begin
          ph_d   = PH_COUNTDOWN;
          cd_d   = 3'(COUNTDOWN_TICKS);
          race_d = '0;
        end
      end
      PH_COUNTDOWN: begin
        if (tick) begin
          if (cd_q == 3'd1) begin
            ph_d = PH_GREEN;
            cd_d = '0;
          end else begin
            cd_d = cd_q - 3'd1;
          end
        end
      end
      PH_GREEN, PH_RED: begin
        if (tick) begin
          race_d = race_q + 8'd1;
          pt_d   = pt_q + PHASE_LEN_W'(1);
          if (pt_d >= cur_len) ph_d = (ph_q == PH_GREEN) ? PH_RED : PH_GREEN;
          // Timeout overrides a light change on the same tick.
          if (race_d == 8'(RACE_TICKS)) ph_d = PH_DONE;
        end
        if (settled) ph_d = PH_DONE;
      end
      default: ph_d = PH_IDLE;
    endcase
    if (ph_d != ph_q) pt_d = '0;
    div_d = ((ph_d != ph_q) || tick) ? '0 : div_q + 1'b1;
  end

  // Phase state, counters and the registered light/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q      <= PH_IDLE;
      div_q     <= '0;
      pt_q      <= '0;
      race_q    <= '0;
      cd_q      <= '0;
      enable    <= 1'b0;
      red       <= 1'b0;
      race_done <= 1'b0;
    end else begin
      ph_q      <= ph_d;
      div_q     <= div_d;
      pt_q      <= pt_d;
      race_q    <= race_d;
      cd_q      <= cd_d;
      enable    <= (ph_d == PH_GREEN) || (ph_d == PH_RED);
      red       <= (ph_d == PH_RED);
      race_done <= (ph_d == PH_DONE);
    end
  end

  race_place_arbiter #(
    .N_PLAYERS (N_PLAYERS)
  ) u_arbiter (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .sample_en   (enable),
    .finished    (finished),
    .out         (out),
    .win         (win),
    .place_valid (place_valid),
    .place_num   (place_num),
    .settled     (settled)
  );

endmodule

// File: tb/tb_race_controller.sv
// tb_race_controller: directed stimulus with a grant scoreboard. Expected
// grants are queued when finish stimulus is driven; a negedge monitor pops
// and compares whenever the DUT presents a win/place_valid pulse.
module tb_race_controller;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] finished;
  logic [N-1:0] out;
  logic         enable;
  logic         red;
  logic [2:0]   phase;
  logic [2:0]   countdown;
  logic [N-1:0] win;
  logic         place_valid;
  logic [2:0]   place_num;
  logic         race_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned lane;
    int unsigned place;
  } grant_t;

  grant_t sb[$];

  race_controller #(
    .N_PLAYERS       (N),
    .TICK_DIV        (2),
    .COUNTDOWN_TICKS (3),
    .GREEN_TICKS     (2),
    .RED_TICKS       (1),
    .RACE_TICKS      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .finished    (finished),
    .out         (out),
    .enable      (enable),
    .red         (red),
    .phase       (phase),
    .countdown   (countdown),
    .win         (win),
    .place_valid (place_valid),
    .place_num   (place_num),
    .race_done   (race_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int unsigned lane, input int unsigned place);
    grant_t g;
    g.lane  = lane;
    g.place = place;
    sb.push_back(g);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_phase"}, 32'(phase), 0);
    check({tag, "_countdown"}, 32'(countdown), 0);
    check({tag, "_enable"}, 32'(enable), 0);
    check({tag, "_red"}, 32'(red), 0);
    check({tag, "_win"}, 32'(win), 0);
    check({tag, "_place_valid"}, 32'(place_valid), 0);
    check({tag, "_place_num"}, 32'(place_num), 0);
    check({tag, "_race_done"}, 32'(race_done), 0);
  endtask

  // Start pulse, then follow the countdown 3,2,1 into GREEN 6 cycles later.
  task automatic start_race();
    int unsigned cd_exp [6] = '{3, 2, 2, 1, 1, 0};
    int unsigned ph_exp [6] = '{1, 1, 1, 1, 1, 2};
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_phase", 32'(phase), 1);
    check("start_countdown", 32'(countdown), 3);
    for (int i = 0; i < 6; i++) begin
      step();
      check("cd_value", 32'(countdown), cd_exp[i]);
      check("cd_phase", 32'(phase), ph_exp[i]);
    end
    check("green_enable", 32'(enable), 1);
    check("green_red", 32'(red), 0);
  endtask

  // Scoreboard monitor: every presented grant must match the queue head.
  always @(negedge clk) begin
    if (place_valid || (win != '0)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: win=%b place_valid=%b place_num=%0d, none expected at %0t",
                 win, place_valid, place_num, $time);
      end else begin
        grant_t e;
        e = sb.pop_front();
        check("grant_win", 32'(win), 32'(1) << e.lane);
        check("grant_valid", 32'(place_valid), 1);
        check("grant_place", 32'(place_num), e.place);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    finished = '0;
    out      = '0;
    #2 rst = 1'b0;
    step();
    step();
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;
    step();
    check("idle_phase", 32'(phase), 0);

    // Race A: countdown, light cadence, two simultaneous finishers, timeout.
    start_race();
    for (int i = 0; i < 12; i++) begin
      check("red_cadence", 32'(red), ((i % 6) >= 4) ? 1 : 0);
      check("enable_cadence", 32'(enable), 1);
      if (i < 11) step();
    end
    finished = 4'b0110;
    expect_grant(1, 1);
    expect_grant(2, 2);
    step();
    step();
    step();
    step();
    check("a_before_timeout_phase", 32'(phase), 2);
    check("a_before_timeout_done", 32'(race_done), 0);
    step();
    check("a_timeout_phase", 32'(phase), 4);
    check("a_timeout_done", 32'(race_done), 1);
    check("a_done_enable", 32'(enable), 0);
    check("a_done_red", 32'(red), 0);

    // Race B: lane 0 out and finished together, lanes 1..3 take places 1..3.
    finished = '0;
    step();
    start_race();
    out      = 4'b0001;
    finished = 4'b1111;
    expect_grant(1, 1);
    expect_grant(2, 2);
    expect_grant(3, 3);
    step();
    step();
    check("b_draining_done", 32'(race_done), 0);
    step();
    check("b_all_resolved_phase", 32'(phase), 4);
    check("b_all_resolved_done", 32'(race_done), 1);
    finished = '0;
    out      = '0;

    // Race C: nobody resolves, DONE after 8 race ticks with no grants.
    step();
    start_race();
    repeat (15) step();
    check("c_tick15_phase", 32'(phase), 2);
    check("c_tick15_done", 32'(race_done), 0);
    step();
    check("c_timeout_phase", 32'(phase), 4);
    check("c_timeout_done", 32'(race_done), 1);

    // Race D: reset while lane 2 is still pending behind lane 1.
    step();
    start_race();
    finished = 4'b0110;
    expect_grant(1, 1);
    step();
    @(negedge clk);
    #1 rst = 1'b0;
    #1 check_reset_values("abort");
    finished = '0;
    step();
    step();
    check_reset_values("abort_hold");
    @(negedge clk);
    rst = 1'b1;
    step();
    check("abort_idle_phase", 32'(phase), 0);
    check("abort_idle_enable", 32'(enable), 0);

    step();
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/race_controller.md
# race_controller

Sequences a multi-lane red-light/green-light race around N per-player step/click lanes. It runs the countdown and alternating light phases and drives the shared `enable`/`red` signals. It arbitrates finish order so each finishing lane receives a unique place via a one-cycle `win` pulse. It sits above the per-player lane logic and below the display/status layer.

## Interface
- `N_PLAYERS`, 4: number of lanes, 2..8.
- `TICK_DIV`, 1000: clk cycles per game tick, ≥2.
- `COUNTDOWN_TICKS`, 3: countdown length in ticks, 1..7.
- `GREEN_TICKS`, 8: green phase length in ticks (fixed mode), ≥1.
- `RED_TICKS`, 4: red phase length in ticks (fixed mode), ≥1.
- `RACE_TICKS`, 255: race timeout in ticks, 8-bit.

- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  level; sampled each cycle, acted on in IDLE/DONE only.
- `finished`  input  N_PLAYERS  lane i reached its step target (level, sticky upstream).
- `out`  input  N_PLAYERS  lane i eliminated (clicked on red), level.
- `enable`  output  1  lanes may count clicks.
- `red`  output  1  red light active.
- `phase`  output  3  0 IDLE, 1 COUNTDOWN, 2 GREEN, 3 RED, 4 DONE.
- `countdown`  output  3  remaining countdown ticks, 0 outside COUNTDOWN.
- `win`  output  N_PLAYERS  one-cycle pulse to the lane being granted a place.
- `place_valid`  output  1  one-cycle pulse coincident with any `win` bit.
- `place_num`  output  3  place granted this cycle, 1-based.
- `race_done`  output  1  high throughout DONE.

## Operation
- Tick prescaler counts 0..TICK_DIV-1 and emits `tick` on wrap; it clears on every phase entry, so the first tick after entry is exactly TICK_DIV cycles later.
- IDLE: `start`=1 → COUNTDOWN with `countdown`=COUNTDOWN_TICKS. The pending mask, resolved mask and place counter (=1) clear.
- COUNTDOWN: each tick decrements `countdown`. A tick while `countdown`=1 → GREEN and `countdown`=0.
- GREEN: after the phase length in ticks → RED. RED: after the phase length in ticks → GREEN. The race tick counter increments in both.
- `enable`=1 in GREEN and RED. `red`=1 in RED only.
- Resolution: a lane resolves when `finished[i]` first seen high, or `out[i]` seen high, while `enable`. Only the first event counts; a resolved lane ignores later inputs.
- Same cycle `finished[i]` and `out[i]` with lane unresolved → eliminated, no place.
- Finishing lanes set pending. Each cycle at most one grant goes to the lowest-index pending lane. A grant pulses `win[i]`, `place_valid` and `place_num`=counter, then increments the counter, saturating at 7. Other pending lanes wait, one per cycle.
- → DONE when all lanes resolved and pending empty, or on race tick count = RACE_TICKS. On timeout, pending grants still drain in DONE; unresolved lanes get no place.
- DONE: `start`=1 → COUNTDOWN with full clear. `start` in any other phase is ignored.
- Inputs used in the same cycle, no synchronizers; lanes share `clk`.

## Timing
- Reset (`rst`=0): phase IDLE, `enable`=0, `red`=0, `countdown`=0, `win`=0, `place_valid`=0, `place_num`=0, `race_done`=0, all masks/counters 0, LFSR seed 8'hA5.
- All outputs are registered.
- `start` high at edge k → `phase`=1 visible after edge k.
- A `finished` edge sampled at cycle k with no other pending → `win` pulse at cycle k+1.
- Phase change occurs on the edge where `tick` fires. `enable`/`red` change on that same edge.
- `rst` asserted mid-race aborts immediately to reset values. No grant is emitted.

## Configuration
- `RACE_RANDOM_LIGHT_EN` defined: phase lengths come from an 8-bit Fibonacci LFSR, taps 8,6,5,4, stepped every cycle.
  - Green length = GREEN_TICKS/2 + (lfsr[2:0]), sampled at GREEN entry.
  - Red length = RED_TICKS/2 + (lfsr[1:0]), sampled at RED entry.
  - Each length has a minimum of 1.
- Not defined: fixed GREEN_TICKS/RED_TICKS. The LFSR is absent.

## Structure
- Shared package `race_pkg`:
  - phase encoding constants (IDLE..DONE, 3-bit);
  - the LFSR seed and tap constant;
  - the place-counter width.
- One sub-module, `race_place_arbiter`: fixed-priority pending-mask grant plus place counter. The phase FSM, prescaler and LFSR stay in `race_controller`.

## Test plan
- TICK_DIV=2, COUNTDOWN_TICKS=3, start pulse → `countdown` 3,2,1 at 2-cycle spacing, then `phase`=2 and `enable`=1 exactly 6 cycles after start.
- Fixed mode, GREEN_TICKS=2, RED_TICKS=1, TICK_DIV=2 → `red` low 4 cycles, high 2 cycles, repeating.
- `finished`=4'b0110 in one cycle → `win`=0010/place 1, then `win`=0100/place 2 on consecutive cycles.
- `out[0]` and `finished[0]` same cycle, lanes 1–3 finish → lane 0 no `win`, places 1..3 to lanes 1..3, `race_done`=1.
- No lane resolves, RACE_TICKS=8 → DONE after 8 race ticks, no `win` pulses.
- `rst` low during GREEN with lane 2 pending → all outputs return to reset values, no `win[2]` pulse.
